// File: rtl/adc_sampler.sv
// adc_sampler: drives a 3-channel SPI ADC and publishes one coherent set of codes
// per trigger edge. Frame per channel: cs_n setup, 16 sclk periods, cs_n hold, gap.
module adc_sampler #(
    parameter int unsigned CLK_DIV = 2,  // sclk half-period in clk cycles, 1..15
    parameter int unsigned CS_GAP  = 4   // cs_n high time between frames, 1..63
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        trigger,
    input  logic        adc_miso,
    output logic        adc_cs_n,
    output logic        adc_sclk,
    output logic        adc_mosi,
    output logic [11:0] Vdc1,
    output logic [11:0] Vdc2,
    output logic [11:0] Iref,
    output logic        data_valid,
    output logic        busy,
    output logic        overrun
);

    localparam logic [5:0] DivLast = 6'(CLK_DIV - 1);
    localparam logic [5:0] GapLast = 6'(CS_GAP - 1);

    typedef enum logic [2:0] {
        StIdle,
        StCsSetup,
        StShift,
        StCsHold,
        StGap,
        StDone
    } state_t;

    state_t      state_q;
    logic [5:0]  cnt_q;    // cycles spent in the current phase
    logic [4:0]  hp_q;     // sclk half-period index within SHIFT
    logic [1:0]  ch_q;     // channel being converted
    logic [15:0] tx_q;     // remaining mosi bits, MSB goes out next
    logic [11:0] sh_q;     // the four leading frame bits fall off the top
    logic [11:0] code0_q;
    logic [11:0] code1_q;
    logic        trig_q;
    logic        armed_q;  // blocks a false edge when trigger is high across reset release
    logic        trig_edge;

    assign trig_edge = trigger & ~trig_q & armed_q;

    // Sequencer: phase timing, SPI pins, code capture and result publication
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            hp_q       <= '0;
            ch_q       <= '0;
            tx_q       <= '0;
            sh_q       <= '0;
            code0_q    <= '0;
            code1_q    <= '0;
            trig_q     <= 1'b0;
            armed_q    <= 1'b0;
            adc_cs_n   <= 1'b1;
            adc_sclk   <= 1'b1;
            adc_mosi   <= 1'b0;
            Vdc1       <= '0;
            Vdc2       <= '0;
            Iref       <= '0;
            data_valid <= 1'b0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            trig_q  <= trigger;
            armed_q <= 1'b1;
            overrun <= trig_edge && (state_q != StIdle);
            case (state_q)
                StIdle: begin
                    if (trig_edge) begin
                        state_q  <= StCsSetup;
                        cnt_q    <= '0;
                        ch_q     <= '0;
                        adc_cs_n <= 1'b0;
                        adc_sclk <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                StCsSetup: begin
                    if (cnt_q == DivLast) begin
                        // First falling sclk edge carries the channel MSB
                        state_q  <= StShift;
                        cnt_q    <= '0;
                        hp_q     <= '0;
                        adc_sclk <= 1'b0;
                        adc_mosi <= ch_q[1];
                        tx_q     <= {ch_q[0], 15'b0};
                    end else begin
                        cnt_q <= cnt_q + 6'd1;
                    end
                end
                StShift: begin
                    if (cnt_q == DivLast) begin
                        cnt_q <= '0;
                        if (hp_q == 5'd31) begin
                            // Last half-period is high; leave sclk high into CS_HOLD
                            state_q <= StCsHold;
                        end else begin
                            hp_q <= hp_q + 5'd1;
                            if (!adc_sclk) begin
                                adc_sclk <= 1'b1;
                                sh_q     <= {sh_q[10:0], adc_miso};
                            end else begin
                                adc_sclk <= 1'b0;
                                adc_mosi <= tx_q[15];
                                tx_q     <= {tx_q[14:0], 1'b0};
                            end
                        end
                    end else begin
                        cnt_q <= cnt_q + 6'd1;
                    end
                end
                StCsHold: begin
                    if (cnt_q == DivLast) begin
                        state_q  <= StGap;
                        cnt_q    <= '0;
                        adc_cs_n <= 1'b1;
                        if (ch_q == 2'd0) code0_q <= sh_q;
                        if (ch_q == 2'd1) code1_q <= sh_q;
                    end else begin
                        cnt_q <= cnt_q + 6'd1;
                    end
                end
                StGap: begin
                    if (cnt_q == GapLast) begin
                        cnt_q <= '0;
                        ch_q  <= ch_q + 2'd1;
                        if (ch_q == 2'd2) begin
                            // Channel 2 is offset binary; flipping the MSB gives two's complement
                            state_q    <= StDone;
                            Vdc1       <= code0_q;
                            Vdc2       <= code1_q;
                            Iref       <= {~sh_q[11], sh_q[10:0]};
                            data_valid <= 1'b1;
                        end else begin
                            state_q  <= StCsSetup;
                            adc_cs_n <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + 6'd1;
                    end
                end
                StDone: begin
                    state_q    <= StIdle;
                    data_valid <= 1'b0;
                    busy       <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_sampler.sv
// tb_adc_sampler: randomized acquisitions against an ADC behavioural model, checking
// latency, published codes, SPI framing, overrun, reset behaviour and a fast configuration.
module tb_adc_sampler;

    localparam int LAT_A = 3 * (34 * 2 + 4) + 1;
    localparam int LAT_B = 3 * (34 * 1 + 1) + 1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        trigger = 1'b0;
    logic        adc_miso = 1'b0;
    logic        adc_cs_n, adc_sclk, adc_mosi, data_valid, busy, overrun;
    logic [11:0] Vdc1, Vdc2, Iref;

    logic        trig_b = 1'b0;
    logic        miso_b = 1'b0;
    logic        cs_n_b, sclk_b, mosi_b, dv_b, busy_b, ovr_b;
    logic [11:0] vdc1_b, vdc2_b, iref_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    adc_sampler dut (
        .clk        (clk),
        .rst        (rst),
        .trigger    (trigger),
        .adc_miso   (adc_miso),
        .adc_cs_n   (adc_cs_n),
        .adc_sclk   (adc_sclk),
        .adc_mosi   (adc_mosi),
        .Vdc1       (Vdc1),
        .Vdc2       (Vdc2),
        .Iref       (Iref),
        .data_valid (data_valid),
        .busy       (busy),
        .overrun    (overrun)
    );

    adc_sampler #(.CLK_DIV(1), .CS_GAP(1)) dut_fast (
        .clk        (clk),
        .rst        (rst),
        .trigger    (trig_b),
        .adc_miso   (miso_b),
        .adc_cs_n   (cs_n_b),
        .adc_sclk   (sclk_b),
        .adc_mosi   (mosi_b),
        .Vdc1       (vdc1_b),
        .Vdc2       (vdc2_b),
        .Iref       (iref_b),
        .data_valid (dv_b),
        .busy       (busy_b),
        .overrun    (ovr_b)
    );

    // ADC model and bus monitor state
    logic [11:0] codes [3];
    logic [11:0] codes_b [3];
    int          fidx = 0;
    int          fidx_b = 0;
    logic [15:0] adc_word = '0;
    logic [15:0] adc_word_b = '0;
    logic [15:0] mword = '0;
    logic        cs_prev = 1'b1, sclk_prev = 1'b1, mosi_prev = 1'b0;
    logic        cs_prev_b = 1'b1, sclk_prev_b = 1'b1;
    int          rises = 0, gap_cnt = 0, n_falls = 0, mosi_err = 0, stab_err = 0;
    int          q_rises[$];
    logic [15:0] q_mosi[$];
    int          q_gaps[$];

    // Reference for the signed current code: offset binary minus mid-scale
    function automatic logic [11:0] iref_ref(input logic [11:0] c);
        int v;
        v = int'(c) - 2048;
        return v[11:0];
    endfunction

    // ADC for the default instance: one frame per cs_n fall, bits change on sclk falls
    always @(negedge clk) begin
        if (rst) begin
            if (cs_prev && !adc_cs_n) begin
                q_gaps.push_back(gap_cnt);
                gap_cnt = 0;
                rises = 0;
                mword = '0;
                n_falls++;
                adc_word = (fidx < 3) ? {4'b0, codes[fidx]} : 16'h0;
                fidx++;
            end
            if (!cs_prev && adc_cs_n) begin
                q_rises.push_back(rises);
                q_mosi.push_back(mword);
            end
            if (adc_cs_n) gap_cnt++;
            if (!sclk_prev && adc_sclk) begin
                rises++;
                mword = {mword[14:0], adc_mosi};
                if (adc_mosi !== mosi_prev) stab_err++;
            end
            if (sclk_prev && !adc_sclk) begin
                adc_miso = adc_word[15];
                adc_word = {adc_word[14:0], 1'b0};
            end else if (adc_mosi !== mosi_prev) begin
                mosi_err++;
            end
        end
        cs_prev = adc_cs_n;
        sclk_prev = adc_sclk;
        mosi_prev = adc_mosi;
    end

    // ADC for the fast instance
    always @(negedge clk) begin
        if (rst) begin
            if (cs_prev_b && !cs_n_b) begin
                adc_word_b = (fidx_b < 3) ? {4'b0, codes_b[fidx_b]} : 16'h0;
                fidx_b++;
            end
            if (sclk_prev_b && !sclk_b) begin
                miso_b = adc_word_b[15];
                adc_word_b = {adc_word_b[14:0], 1'b0};
            end
        end
        cs_prev_b = cs_n_b;
        sclk_prev_b = sclk_b;
    end

    // One acquisition on the default instance; optional second edge at cycle edge2
    task automatic acquire(input int edge2, output int lat, output int dv_n, output int ovr_n,
                           output logic busy0, output logic busy1, output logic busy_after);
        lat = -1; dv_n = 0; ovr_n = 0; busy1 = 1'bx; busy_after = 1'bx;
        q_rises.delete(); q_mosi.delete(); q_gaps.delete();
        n_falls = 0; mosi_err = 0; stab_err = 0; fidx = 0;
        @(negedge clk);
        trigger = 1'b1;
        busy0 = busy;
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            if (k == 1) busy1 = busy;
            if (data_valid) begin
                dv_n++;
                if (lat < 0) lat = k;
            end
            if (overrun) ovr_n++;
            if (lat > 0 && k == lat + 1) busy_after = busy;
            if (k == 2) trigger = 1'b0;
            if (k == edge2) trigger = 1'b1;
            if (k == edge2 + 2) trigger = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (adc_cs_n !== 1'b1) begin errors++; $display("FAIL reset_cs_n got=%b want=1", adc_cs_n); end
        checks++; if (adc_sclk !== 1'b1) begin errors++; $display("FAIL reset_sclk got=%b want=1", adc_sclk); end
        checks++; if (adc_mosi !== 1'b0) begin errors++; $display("FAIL reset_mosi got=%b want=0", adc_mosi); end
        checks++; if ({Vdc1, Vdc2, Iref} !== 36'h0) begin errors++; $display("FAIL reset_codes got=%h want=0", {Vdc1, Vdc2, Iref}); end
        checks++; if ({data_valid, busy, overrun} !== 3'b000) begin errors++; $display("FAIL reset_flags got=%b want=000", {data_valid, busy, overrun}); end
        rst = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_basic();
        int lat, dv_n, ovr_n;
        logic b0, b1, ba;
        codes[0] = 12'h7FF; codes[1] = 12'h400; codes[2] = 12'h800;
        acquire(-1, lat, dv_n, ovr_n, b0, b1, ba);
        checks++; if (lat !== LAT_A) begin errors++; $display("FAIL basic_latency got=%0d want=%0d", lat, LAT_A); end
        checks++; if (dv_n !== 1) begin errors++; $display("FAIL basic_dv_count got=%0d want=1", dv_n); end
        checks++; if (ovr_n !== 0) begin errors++; $display("FAIL basic_overrun got=%0d want=0", ovr_n); end
        checks++; if (Vdc1 !== 12'h7FF) begin errors++; $display("FAIL basic_vdc1 got=%h want=7ff", Vdc1); end
        checks++; if (Vdc2 !== 12'h400) begin errors++; $display("FAIL basic_vdc2 got=%h want=400", Vdc2); end
        checks++; if (Iref !== 12'h000) begin errors++; $display("FAIL basic_iref got=%h want=000", Iref); end
        checks++; if ({b0, b1, ba} !== 3'b010) begin errors++; $display("FAIL basic_busy_window got=%b want=010", {b0, b1, ba}); end
        checks++; if (q_rises.size() !== 3) begin errors++; $display("FAIL basic_frames got=%0d want=3", q_rises.size()); end
        for (int f = 0; f < 3 && f < q_rises.size(); f++) begin
            checks++; if (q_rises[f] !== 16) begin errors++; $display("FAIL frame%0d_rises got=%0d want=16", f, q_rises[f]); end
            checks++; if (q_mosi[f] !== 16'(f << 14)) begin errors++; $display("FAIL frame%0d_mosi got=%h want=%h", f, q_mosi[f], 16'(f << 14)); end
        end
        for (int f = 1; f < 3 && f < q_gaps.size(); f++) begin
            checks++; if (q_gaps[f] !== 4) begin errors++; $display("FAIL gap%0d got=%0d want=4", f, q_gaps[f]); end
        end
        checks++; if (mosi_err !== 0) begin errors++; $display("FAIL mosi_off_fall got=%0d want=0", mosi_err); end
        checks++; if (stab_err !== 0) begin errors++; $display("FAIL mosi_at_rise got=%0d want=0", stab_err); end
    endtask

    task automatic test_iref_extremes();
        int lat, dv_n, ovr_n;
        logic b0, b1, ba;
        codes[0] = 12'h123; codes[1] = 12'h456; codes[2] = 12'hFFF;
        acquire(-1, lat, dv_n, ovr_n, b0, b1, ba);
        checks++; if (Iref !== 12'h7FF) begin errors++; $display("FAIL iref_max got=%h want=7ff", Iref); end
        codes[2] = 12'h000;
        acquire(-1, lat, dv_n, ovr_n, b0, b1, ba);
        checks++; if (Iref !== 12'h800) begin errors++; $display("FAIL iref_min got=%h want=800", Iref); end
        checks++; if (Vdc1 !== 12'h123 || Vdc2 !== 12'h456) begin errors++; $display("FAIL iref_vdc got=%h/%h want=123/456", Vdc1, Vdc2); end
    endtask

    task automatic test_random();
        int lat, dv_n, ovr_n;
        logic b0, b1, ba;
        for (int i = 0; i < 4; i++) begin
            for (int c = 0; c < 3; c++) codes[c] = 12'($urandom_range(0, 4095));
            acquire(-1, lat, dv_n, ovr_n, b0, b1, ba);
            checks++; if (lat !== LAT_A) begin errors++; $display("FAIL rand%0d_latency got=%0d want=%0d", i, lat, LAT_A); end
            checks++; if (Vdc1 !== codes[0]) begin errors++; $display("FAIL rand%0d_vdc1 got=%h want=%h", i, Vdc1, codes[0]); end
            checks++; if (Vdc2 !== codes[1]) begin errors++; $display("FAIL rand%0d_vdc2 got=%h want=%h", i, Vdc2, codes[1]); end
            checks++; if (Iref !== iref_ref(codes[2])) begin errors++; $display("FAIL rand%0d_iref got=%h want=%h", i, Iref, iref_ref(codes[2])); end
        end
    endtask

    task automatic test_overrun();
        int lat, dv_n, ovr_n;
        logic b0, b1, ba;
        codes[0] = 12'hABC; codes[1] = 12'h0F0; codes[2] = 12'h801;
        acquire(50, lat, dv_n, ovr_n, b0, b1, ba);
        checks++; if (ovr_n !== 1) begin errors++; $display("FAIL ovr50_count got=%0d want=1", ovr_n); end
        checks++; if (dv_n !== 1) begin errors++; $display("FAIL ovr50_dv got=%0d want=1", dv_n); end
        checks++; if (ba !== 1'b0) begin errors++; $display("FAIL ovr50_busy_after got=%b want=0", ba); end
        checks++; if (Iref !== 12'h001) begin errors++; $display("FAIL ovr50_iref got=%h want=001", Iref); end
    endtask

    task automatic test_done_edge();
        int lat, dv_n, ovr_n;
        logic b0, b1, ba;
        acquire(LAT_A, lat, dv_n, ovr_n, b0, b1, ba);
        checks++; if (ovr_n !== 1) begin errors++; $display("FAIL done_edge_ovr got=%0d want=1", ovr_n); end
        checks++; if (dv_n !== 1) begin errors++; $display("FAIL done_edge_dv got=%0d want=1", dv_n); end
        checks++; if (n_falls !== 3) begin errors++; $display("FAIL done_edge_frames got=%0d want=3", n_falls); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL done_edge_busy got=%b want=0", busy); end
    endtask

    task automatic test_reset_mid();
        int dv_n, busy_n, lat, ovr_n;
        logic b0, b1, ba;
        fidx = 0;
        @(negedge clk);
        trigger = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (k == 2) trigger = 1'b0;
        end
        rst = 1'b0;
        #1;
        checks++; if ({adc_cs_n, adc_sclk, adc_mosi} !== 3'b110) begin errors++; $display("FAIL mid_rst_pins got=%b want=110", {adc_cs_n, adc_sclk, adc_mosi}); end
        checks++; if ({Vdc1, Vdc2, Iref} !== 36'h0) begin errors++; $display("FAIL mid_rst_codes got=%h want=0", {Vdc1, Vdc2, Iref}); end
        checks++; if ({data_valid, busy, overrun} !== 3'b000) begin errors++; $display("FAIL mid_rst_flags got=%b want=000", {data_valid, busy, overrun}); end
        @(negedge clk);
        rst = 1'b1;
        dv_n = 0; busy_n = 0;
        repeat (300) begin
            @(negedge clk);
            if (data_valid) dv_n++;
            if (busy) busy_n++;
        end
        checks++; if (dv_n !== 0 || busy_n !== 0) begin errors++; $display("FAIL mid_rst_quiet got=%0d/%0d want=0/0", dv_n, busy_n); end
        codes[0] = 12'h321; codes[1] = 12'hFED; codes[2] = 12'h7FF;
        acquire(-1, lat, dv_n, ovr_n, b0, b1, ba);
        checks++; if (lat !== LAT_A) begin errors++; $display("FAIL mid_rst_relat got=%0d want=%0d", lat, LAT_A); end
        checks++; if (Iref !== 12'hFFF || Vdc2 !== 12'hFED) begin errors++; $display("FAIL mid_rst_vals got=%h/%h want=fff/fed", Iref, Vdc2); end
    endtask

    task automatic test_trigger_held();
        int busy_n, lat, dv_n, ovr_n;
        logic b0, b1, ba;
        @(negedge clk);
        trigger = 1'b1;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        busy_n = 0;
        repeat (50) begin
            @(negedge clk);
            if (busy) busy_n++;
        end
        checks++; if (busy_n !== 0) begin errors++; $display("FAIL held_trigger_busy got=%0d want=0", busy_n); end
        trigger = 1'b0;
        @(negedge clk);
        codes[0] = 12'h001; codes[1] = 12'hFFE; codes[2] = 12'h3C5;
        acquire(-1, lat, dv_n, ovr_n, b0, b1, ba);
        checks++; if (lat !== LAT_A) begin errors++; $display("FAIL held_latency got=%0d want=%0d", lat, LAT_A); end
        checks++; if (Vdc1 !== 12'h001 || Iref !== iref_ref(12'h3C5)) begin errors++; $display("FAIL held_vals got=%h/%h want=001/%h", Vdc1, Iref, iref_ref(12'h3C5)); end
    endtask

    task automatic test_fast();
        int lat;
        for (int i = 0; i < 2; i++) begin
            for (int c = 0; c < 3; c++) codes_b[c] = 12'($urandom_range(0, 4095));
            fidx_b = 0;
            lat = -1;
            @(negedge clk);
            trig_b = 1'b1;
            for (int k = 1; k <= 200; k++) begin
                @(negedge clk);
                if (k == 2) trig_b = 1'b0;
                if (dv_b && lat < 0) lat = k;
            end
            checks++; if (lat !== LAT_B) begin errors++; $display("FAIL fast%0d_latency got=%0d want=%0d", i, lat, LAT_B); end
            checks++; if (vdc1_b !== codes_b[0] || vdc2_b !== codes_b[1]) begin errors++; $display("FAIL fast%0d_vdc got=%h/%h want=%h/%h", i, vdc1_b, vdc2_b, codes_b[0], codes_b[1]); end
            checks++; if (iref_b !== iref_ref(codes_b[2])) begin errors++; $display("FAIL fast%0d_iref got=%h want=%h", i, iref_b, iref_ref(codes_b[2])); end
        end
    endtask

    initial begin
        for (int c = 0; c < 3; c++) begin
            codes[c] = '0;
            codes_b[c] = '0;
        end
        test_reset();
        test_basic();
        test_iref_extremes();
        test_random();
        test_overrun();
        test_done_edge();
        test_reset_mid();
        test_trigger_held();
        test_fast();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/adc_sampler.md
ADC_SAMPLER -- requirements
Module: adc_sampler

Interface
REQ-001 Parameter CLK_DIV, default 2: SCLK half-period in clk cycles; legal range 1..15.
REQ-002 Parameter CS_GAP, default 4: cs_n high time between frames, in clk cycles; legal range 1..63.
REQ-003 clk  input  1  system clock, 100 MHz, all logic on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 trigger  input  1  acquisition request; start on detected 0->1 transition.
REQ-006 adc_miso  input  1  serial data from ADC.
REQ-007 adc_cs_n  output  1  ADC chip select, active-low.
REQ-008 adc_sclk  output  1  ADC serial clock, idle high.
REQ-009 adc_mosi  output  1  serial channel address to ADC.
REQ-010 Vdc1  output  12  unsigned bus-1 voltage code, ADC channel 0.
REQ-011 Vdc2  output  12  unsigned bus-2 voltage code, ADC channel 1.
REQ-012 Iref  output  12  signed two's-complement current code, ADC channel 2.
REQ-013 data_valid  output  1  one-cycle pulse when Vdc1/Vdc2/Iref update.
REQ-014 busy  output  1  high from acquisition start until the data_valid cycle, inclusive.
REQ-015 overrun  output  1  one-cycle pulse when a trigger edge is detected while busy.

Function
REQ-016 Trigger edge detection SHALL use one registered copy of trigger; an edge is trigger=1 with previous sample 0.
REQ-017 FSM states: IDLE, CS_SETUP, SHIFT, CS_HOLD, GAP, DONE.
REQ-018 IDLE -> CS_SETUP on trigger edge; channel index set to 0; busy asserts the following cycle.
REQ-019 CS_SETUP: cs_n low, sclk high, CLK_DIV cycles.
REQ-020 SHIFT: 32 half-periods of CLK_DIV cycles each, starting with sclk low; 16 falling and 16 rising sclk edges.
REQ-021 mosi SHALL change only on sclk falling edges; bits 15..14 carry channel index MSB first, remaining bits 0.
REQ-022 miso SHALL be sampled on each sclk rising edge into a 16-bit shift register, MSB first; bits 11..0 of the frame are the conversion code.
REQ-023 CS_HOLD: sclk high, cs_n low, CLK_DIV cycles; then GAP: cs_n high, CS_GAP cycles.
REQ-024 After GAP, channel index increments and FSM returns to CS_SETUP if index < 2, else enters DONE.
REQ-025 Codes for channels 0 and 1 SHALL be held in internal registers; outputs SHALL not change mid-acquisition.
REQ-026 DONE (one cycle): Vdc1, Vdc2, Iref update together; data_valid=1; busy=1; next state IDLE.
REQ-027 Iref SHALL equal channel-2 offset-binary code with bit 11 inverted (0x800 -> 0, 0xFFF -> +2047, 0x000 -> -2048).
REQ-028 Latency: data_valid SHALL assert exactly 3*(34*CLK_DIV + CS_GAP) + 1 cycles after the edge-detect cycle (217 with defaults).
REQ-029 Trigger edges while busy SHALL be ignored for sequencing and SHALL pulse overrun for one cycle each.
REQ-030 Trigger edge coinciding with DONE counts as overrun; no new acquisition starts.
REQ-031 In IDLE: cs_n=1, sclk=1, mosi=0; outputs hold last values.

Reset
REQ-032 rst=0 SHALL immediately force: FSM IDLE, cs_n=1, sclk=1, mosi=0, Vdc1=Vdc2=Iref=0, data_valid=0, busy=0, overrun=0, edge register=0, internal codes 0.
REQ-033 Reset mid-acquisition SHALL discard partial data; outputs read 0, and no data_valid until a full new acquisition completes.
REQ-034 First trigger edge after rst rises SHALL start a normal acquisition; trigger held high through reset release SHALL not start one.

Verification
REQ-035 ADC model returns ch0=0x7FF, ch1=0x400, ch2=0x800; single trigger pulse -> data_valid 217 cycles later, Vdc1=0x7FF, Vdc2=0x400, Iref=0.
REQ-036 ch2=0xFFF then 0x000 on consecutive acquisitions -> Iref=+2047 (0x7FF) then -2048 (0x800).
REQ-037 Monitor cs_n/sclk/mosi -> 3 frames of 16 rising edges, mosi bits 15..14 = 00, 01, 10; mosi stable around every rising edge; cs_n high 4 cycles between frames.
REQ-038 Second trigger edge 50 cycles after first -> overrun pulses once, only one data_valid, busy low immediately after data_valid cycle.
REQ-039 rst low at cycle 100 of an acquisition -> cs_n=1, sclk=1, all outputs 0 same cycle; no data_valid until next trigger plus 217 cycles.
REQ-040 CLK_DIV=1, CS_GAP=1 -> latency 106 cycles, values correct.
